// File: rtl/conv_kxk_pipe.sv
// -----------------------------------------------------------------------------
// conv_kxk_pipe
// Applies a runtime-loadable signed KxK kernel to each incoming RGB chunk and
// emits one filtered RGB pixel per chunk. The pipeline has three register
// stages (products, adder tree, post-process) with valid/ready backpressure.
//
// Ports
//   clk       : clock
//   rst       : asynchronous active-low reset
//   i_data    : K*K pixels, pixel p at [p*3*PW +: 3*PW], {red, grn, blu}
//   i_mode    : 0/3 bypass (centre pixel), 1 clamp, 2 absolute value
//   i_last    : end-of-line marker, travels with the beat
//   i_vld     : input beat valid
//   i_rdy     : input ready (combinational, equals pipeline advance)
//   o_data    : filtered pixel {red, grn, blu}
//   o_last    : delayed i_last
//   o_vld     : output valid
//   o_rdy     : downstream ready
//   k_we      : shadow coefficient write enable
//   k_addr    : coefficient index 0..K*K-1 (larger indices are ignored)
//   k_wdata   : signed coefficient value
//   k_commit  : copy shadow coefficient bank into the active bank
// -----------------------------------------------------------------------------
module conv_kxk_pipe #(
    parameter int K     = 3,
    parameter int PW    = 8,
    parameter int CW    = 9,
    parameter int SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [K*K*3*PW-1:0]   i_data,
    input  logic [1:0]            i_mode,
    input  logic                  i_last,
    input  logic                  i_vld,
    output logic                  i_rdy,
    output logic [3*PW-1:0]       o_data,
    output logic                  o_last,
    output logic                  o_vld,
    input  logic                  o_rdy,
    input  logic                  k_we,
    input  logic [4:0]            k_addr,
    input  logic [CW-1:0]         k_wdata,
    input  logic                  k_commit
);

    localparam int NP  = K * K;
    localparam int CTR = (NP - 1) / 2;
    localparam int MW  = PW + CW + 1;
    localparam int SW  = MW + $clog2(NP);

    // Identity kernel centre tap: 2^SHIFT so the normalising shift cancels it.
    localparam logic [CW-1:0]        COEF_ID = {{(CW-1){1'b0}}, 1'b1} << SHIFT;
    localparam logic signed [SW-1:0] MAXV    = $signed({{(SW-PW){1'b0}}, {PW{1'b1}}});

    // Coefficient banks
    logic signed [CW-1:0] shadow_q [NP];
    logic signed [CW-1:0] active_q [NP];

    // Stage 1: products plus sideband
    logic signed [MW-1:0] prod_d [NP*3];
    logic signed [MW-1:0] prod_q [NP*3];
    logic                 s1_vld_q;
    logic [3*PW-1:0]      s1_ctr_q;
    logic [1:0]           s1_mode_q;
    logic                 s1_last_q;

    // Stage 2: channel sums plus sideband
    logic signed [SW-1:0] sum_d [3];
    logic signed [SW-1:0] sum_q [3];
    logic                 s2_vld_q;
    logic [3*PW-1:0]      s2_ctr_q;
    logic [1:0]           s2_mode_q;
    logic                 s2_last_q;

    // Stage 3: output register
    logic [3*PW-1:0]      out_d;
    logic [3*PW-1:0]      o_data_q;
    logic                 o_vld_q;
    logic                 o_last_q;

    logic                 advance_s;

    // Saturate a (possibly negative) shifted sum into the unsigned pixel range.
    function automatic logic [PW-1:0] sat_pix(input logic signed [SW-1:0] v);
        logic [PW-1:0] r;
        if (v < $signed({SW{1'b0}})) begin
            r = {PW{1'b0}};
        end else if (v > MAXV) begin
            r = {PW{1'b1}};
        end else begin
            r = v[PW-1:0];
        end
        return r;
    endfunction

    // Two's complement magnitude; the most negative value is unreachable here.
    function automatic logic signed [SW-1:0] abs_sum(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] r;
        if (v[SW-1]) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign advance_s = o_rdy | ~o_vld_q;
    assign i_rdy     = advance_s;
    assign o_data    = o_data_q;
    assign o_vld     = o_vld_q;
    assign o_last    = o_last_q;

    // Shadow writes and shadow-to-active commit; a same-cycle write is not
    // seen by the commit because both read the pre-edge shadow contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NP; i++) begin
                shadow_q[i] <= (i == CTR) ? $signed(COEF_ID) : $signed({CW{1'b0}});
                active_q[i] <= (i == CTR) ? $signed(COEF_ID) : $signed({CW{1'b0}});
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (k_we && (k_addr == 5'(i))) begin
                    shadow_q[i] <= k_wdata;
                end
                if (k_commit) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    // Per-channel products: pixel zero-extended, coefficient sign-extended.
    always_comb begin
        for (int j = 0; j < NP*3; j++) begin
            prod_d[j] = {MW{1'b0}};
        end
        for (int p = 0; p < NP; p++) begin
            for (int c = 0; c < 3; c++) begin
                prod_d[p*3+c] = $signed({{(MW-PW){1'b0}}, i_data[(p*3+c)*PW +: PW]})
                              * $signed({{(MW-CW){active_q[p][CW-1]}}, active_q[p]});
            end
        end
    end

    // Stage 1 register: products sampled with the active bank at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_ctr_q  <= {(3*PW){1'b0}};
            s1_mode_q <= 2'd0;
            s1_last_q <= 1'b0;
            for (int j = 0; j < NP*3; j++) begin
                prod_q[j] <= {MW{1'b0}};
            end
        end else if (advance_s) begin
            s1_vld_q  <= i_vld;
            s1_ctr_q  <= i_data[CTR*3*PW +: 3*PW];
            s1_mode_q <= i_mode;
            s1_last_q <= i_last;
            for (int j = 0; j < NP*3; j++) begin
                prod_q[j] <= prod_d[j];
            end
        end
    end

    // Adder tree per channel; SW is wide enough that no partial sum overflows.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            sum_d[c] = {SW{1'b0}};
            for (int p = 0; p < NP; p++) begin
                sum_d[c] = sum_d[c] + SW'(prod_q[p*3+c]);
            end
        end
    end

    // Stage 2 register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld_q  <= 1'b0;
            s2_ctr_q  <= {(3*PW){1'b0}};
            s2_mode_q <= 2'd0;
            s2_last_q <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                sum_q[c] <= {SW{1'b0}};
            end
        end else if (advance_s) begin
            s2_vld_q  <= s1_vld_q;
            s2_ctr_q  <= s1_ctr_q;
            s2_mode_q <= s1_mode_q;
            s2_last_q <= s1_last_q;
            for (int c = 0; c < 3; c++) begin
                sum_q[c] <= sum_d[c];
            end
        end
    end

    // Post-process: normalise and saturate, or pass the centre pixel through.
    always_comb begin
        out_d = {(3*PW){1'b0}};
        for (int c = 0; c < 3; c++) begin
            case (s2_mode_q)
                2'd1:    out_d[c*PW +: PW] = sat_pix(sum_q[c] >>> SHIFT);
                2'd2:    out_d[c*PW +: PW] = sat_pix(abs_sum(sum_q[c]) >>> SHIFT);
                default: out_d[c*PW +: PW] = s2_ctr_q[c*PW +: PW];
            endcase
        end
    end

    // Output register; held stable while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_vld_q  <= 1'b0;
            o_data_q <= {(3*PW){1'b0}};
            o_last_q <= 1'b0;
        end else if (advance_s) begin
            o_vld_q  <= s2_vld_q;
            o_data_q <= out_d;
            o_last_q <= s2_last_q;
        end
    end

endmodule

// File: tb/tb_conv_kxk_pipe.sv
// -----------------------------------------------------------------------------
// tb_conv_kxk_pipe
// Directed bench for conv_kxk_pipe. Unit 0 uses SHIFT=0, unit 1 uses SHIFT=3.
// Stimulus pushes hand-computed expectations into a per-unit queue; a monitor
// per unit pops and compares whenever the DUT transfers an output beat.
// -----------------------------------------------------------------------------
module tb_conv_kxk_pipe;

    localparam int K  = 3;
    localparam int PW = 8;
    localparam int CW = 9;
    localparam int W  = K*K*3*PW;

    typedef struct packed {
        logic [23:0] data;
        logic        last;
        logic [15:0] id;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [W-1:0]  i_data   [2];
    logic [1:0]    i_mode   [2];
    logic          i_last   [2];
    logic          i_vld    [2];
    logic          i_rdy    [2];
    logic [23:0]   o_data   [2];
    logic          o_last   [2];
    logic          o_vld    [2];
    logic          o_rdy    [2];
    logic          k_we     [2];
    logic [4:0]    k_addr   [2];
    logic [CW-1:0] k_wdata  [2];
    logic          k_commit [2];

    exp_t          q0 [$];
    exp_t          q1 [$];
    int            checks;
    int            fails;
    int            next_id;
    logic          stalled  [2];
    logic [23:0]   held     [2];

    conv_kxk_pipe #(.K(K), .PW(PW), .CW(CW), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .i_data(i_data[0]), .i_mode(i_mode[0]), .i_last(i_last[0]),
        .i_vld(i_vld[0]), .i_rdy(i_rdy[0]),
        .o_data(o_data[0]), .o_last(o_last[0]), .o_vld(o_vld[0]), .o_rdy(o_rdy[0]),
        .k_we(k_we[0]), .k_addr(k_addr[0]), .k_wdata(k_wdata[0]), .k_commit(k_commit[0])
    );

    conv_kxk_pipe #(.K(K), .PW(PW), .CW(CW), .SHIFT(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_data(i_data[1]), .i_mode(i_mode[1]), .i_last(i_last[1]),
        .i_vld(i_vld[1]), .i_rdy(i_rdy[1]),
        .o_data(o_data[1]), .o_last(o_last[1]), .o_vld(o_vld[1]), .o_rdy(o_rdy[1]),
        .k_we(k_we[1]), .k_addr(k_addr[1]), .k_wdata(k_wdata[1]), .k_commit(k_commit[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chunk builder: columns 0/1/2 take l/m/r, the centre pixel takes c.
    function automatic logic [W-1:0] chunk(input logic [23:0] l, input logic [23:0] m,
                                           input logic [23:0] r, input logic [23:0] c);
        logic [W-1:0] v;
        v = {W{1'b0}};
        for (int p = 0; p < K*K; p++) begin
            if (p == 4)          v[p*24 +: 24] = c;
            else if (p % 3 == 0) v[p*24 +: 24] = l;
            else if (p % 3 == 1) v[p*24 +: 24] = m;
            else                 v[p*24 +: 24] = r;
        end
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one beat; the expectation is queued before the beat is offered.
    task automatic send(input int u, input logic [W-1:0] d, input logic [1:0] m,
                        input logic l, input logic [23:0] ed);
        exp_t e;
        logic acc;
        e.data = ed;
        e.last = l;
        e.id   = 16'(next_id);
        next_id++;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
        i_data[u] = d;
        i_mode[u] = m;
        i_last[u] = l;
        i_vld[u]  = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = i_rdy[u];
            @(posedge clk);
            #1;
        end
        i_vld[u] = 1'b0;
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout unit %0d beat %0d: got no i_rdy expected i_rdy=1", u, e.id);
        end
    endtask

    task automatic wcoef(input int u, input logic [4:0] a, input logic [CW-1:0] v);
        k_we[u]    = 1'b1;
        k_addr[u]  = a;
        k_wdata[u] = v;
        tick();
        k_we[u] = 1'b0;
    endtask

    task automatic commit(input int u);
        k_commit[u] = 1'b1;
        tick();
        k_commit[u] = 1'b0;
    endtask

    task automatic drain(input int u);
        int n;
        n = 0;
        while (((u == 0) ? q0.size() : q1.size()) != 0 && n < 200) begin
            tick();
            n++;
        end
        if (((u == 0) ? q0.size() : q1.size()) != 0) begin
            checks++;
            fails++;
            $display("FAIL drain unit %0d: got %0d pending expected 0", u,
                     (u == 0) ? q0.size() : q1.size());
        end
    endtask

    // Monitor: stability while stalled, and scoreboard compare on transfer.
    task automatic mon(input int u);
        exp_t e;
        logic have;
        if (rst && o_vld[u]) begin
            if (stalled[u]) begin
                checks++;
                if (o_data[u] !== held[u]) begin
                    fails++;
                    $display("FAIL stall_stable unit %0d: got %h expected %h", u, o_data[u], held[u]);
                end
            end
            if (o_rdy[u]) begin
                stalled[u] = 1'b0;
                have = 1'b1;
                e = '0;
                if (u == 0) begin
                    if (q0.size() == 0) have = 1'b0;
                    else e = q0.pop_front();
                end else begin
                    if (q1.size() == 0) have = 1'b0;
                    else e = q1.pop_front();
                end
                checks++;
                if (!have) begin
                    fails++;
                    $display("FAIL unexpected_output unit %0d: got data %h expected no beat", u, o_data[u]);
                end else if (o_data[u] !== e.data || o_last[u] !== e.last) begin
                    fails++;
                    $display("FAIL sb unit %0d beat %0d: got data %h last %b expected data %h last %b",
                             u, e.id, o_data[u], o_last[u], e.data, e.last);
                end
            end else begin
                stalled[u] = 1'b1;
                held[u]    = o_data[u];
            end
        end else begin
            stalled[u] = 1'b0;
        end
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] wht;
        logic [23:0] zro;
        wht     = 24'hFFFFFF;
        zro     = 24'h000000;
        checks  = 0;
        fails   = 0;
        next_id = 0;
        rst     = 1'b0;
        for (int u = 0; u < 2; u++) begin
            i_data[u] = {W{1'b0}};  i_mode[u] = 2'd0;  i_last[u] = 1'b0;
            i_vld[u] = 1'b0;        o_rdy[u] = 1'b1;   k_we[u] = 1'b0;
            k_addr[u] = 5'd0;       k_wdata[u] = {CW{1'b0}};
            k_commit[u] = 1'b0;     stalled[u] = 1'b0; held[u] = 24'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state
        chk("rst_o_vld",  32'(o_vld[0]),  32'd0);
        chk("rst_o_data", 32'(o_data[0]), 32'd0);
        chk("rst_o_last", 32'(o_last[0]), 32'd0);
        chk("rst_i_rdy",  32'(i_rdy[0]),  32'd1);
        chk("rst_o_vld1", 32'(o_vld[1]),  32'd0);

        // Unit 1 (SHIFT=3): identity kernel has centre 8
        send(1, chunk(wht, wht, wht, {8'd10, 8'd20, 8'd30}), 2'd1, 1'b0, {8'd10, 8'd20, 8'd30});
        drain(1);
        // Box blur with all-ones kernel
        for (int a = 0; a < 9; a++) wcoef(1, 5'(a), 9'd1);
        commit(1);
        send(1, chunk(24'h505050, 24'h505050, 24'h505050, 24'h505050), 2'd1, 1'b0, {8'd90, 8'd90, 8'd90});
        send(1, chunk(wht, wht, wht, wht), 2'd1, 1'b1, {8'd255, 8'd255, 8'd255});
        send(1, chunk(24'h50FF00, 24'h50FF00, 24'h50FF00, 24'h50FF00), 2'd1, 1'b0, {8'd90, 8'd255, 8'd0});
        send(1, chunk(24'h505050, 24'h505050, 24'h505050, 24'h505050), 2'd2, 1'b0, {8'd90, 8'd90, 8'd90});
        drain(1);

        // Unit 0: identity after reset with exact latency
        send(0, chunk(wht, wht, wht, {8'd10, 8'd20, 8'd30}), 2'd1, 1'b1, {8'd10, 8'd20, 8'd30});
        chk("lat_e0", 32'(o_vld[0]), 32'd0);
        tick();
        chk("lat_e1", 32'(o_vld[0]), 32'd0);
        tick();
        chk("lat_e2", 32'(o_vld[0]), 32'd1);
        drain(0);

        // Sobel-X kernel
        wcoef(0, 5'd0, 9'h1FF); wcoef(0, 5'd1, 9'd0); wcoef(0, 5'd2, 9'd1);
        wcoef(0, 5'd3, 9'h1FE); wcoef(0, 5'd4, 9'd0); wcoef(0, 5'd5, 9'd2);
        wcoef(0, 5'd6, 9'h1FF); wcoef(0, 5'd7, 9'd0); wcoef(0, 5'd8, 9'd1);
        commit(0);
        send(0, chunk(24'hC80000, zro, zro, zro), 2'd1, 1'b0, 24'h000000);
        send(0, chunk(24'hC80000, zro, zro, zro), 2'd2, 1'b0, 24'hFF0000);
        send(0, chunk(24'h0A0000, zro, zro, zro), 2'd2, 1'b0, 24'h280000);
        send(0, chunk(zro, zro, 24'h0A0000, zro), 2'd1, 1'b0, 24'h280000);
        send(0, chunk(24'h0A0000, zro, zro, 24'h070809), 2'd3, 1'b1, 24'h070809);
        drain(0);

        // Backpressure in bypass mode
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(0, chunk(wht, wht, wht, {8'(16+i), 8'(32+i), 8'(48+i)}), 2'd0,
                         (i == 7), {8'(16+i), 8'(32+i), 8'(48+i)});
                end
            end
            begin
                repeat (3) tick();
                o_rdy[0] = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_i_rdy", 32'(i_rdy[0]), 32'd0);
                    @(posedge clk);
                    #1;
                end
                o_rdy[0] = 1'b1;
            end
        join
        drain(0);

        // Commit in the same cycle as an acceptance
        wcoef(0, 5'd0, 9'd0); wcoef(0, 5'd1, 9'd0); wcoef(0, 5'd2, 9'd0);
        wcoef(0, 5'd3, 9'd0); wcoef(0, 5'd4, 9'd2); wcoef(0, 5'd5, 9'd0);
        wcoef(0, 5'd6, 9'd0); wcoef(0, 5'd7, 9'd0); wcoef(0, 5'd8, 9'd0);
        wcoef(0, 5'd9, 9'd1);
        wcoef(0, 5'd31, 9'd1);
        k_commit[0] = 1'b1;
        k_we[0]     = 1'b1;
        k_addr[0]   = 5'd4;
        k_wdata[0]  = 9'd3;
        send(0, chunk(24'h0A141E, 24'h010101, zro, 24'h050607), 2'd2, 1'b0, {8'd40, 8'd80, 8'd120});
        k_commit[0] = 1'b0;
        k_we[0]     = 1'b0;
        send(0, chunk(24'h0A141E, 24'h010101, zro, 24'h050607), 2'd2, 1'b0, {8'd10, 8'd12, 8'd14});
        commit(0);
        send(0, chunk(24'h0A141E, 24'h010101, zro, 24'h050607), 2'd2, 1'b1, {8'd15, 8'd18, 8'd21});
        drain(0);

        // Asynchronous reset with three beats in flight
        send(0, chunk(wht, wht, wht, 24'h111111), 2'd0, 1'b0, 24'h111111);
        send(0, chunk(wht, wht, wht, 24'h222222), 2'd0, 1'b0, 24'h222222);
        send(0, chunk(wht, wht, wht, 24'h333333), 2'd0, 1'b0, 24'h333333);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_o_vld",  32'(o_vld[0]),  32'd0);
        chk("arst_o_data", 32'(o_data[0]), 32'd0);
        q0.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) begin
            tick();
            chk("post_rst_idle", 32'(o_vld[0]), 32'd0);
        end
        commit(0);
        send(0, chunk(wht, wht, wht, {8'd10, 8'd20, 8'd30}), 2'd1, 1'b1, {8'd10, 8'd20, 8'd30});
        drain(0);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/conv_kxk_pipe.md
Name: conv_kxk_pipe

Overview:
- Parametrised successor to the 3x3 RGB convolution stage: applies a runtime-loadable signed KxK kernel to each incoming RGB chunk and emits one filtered RGB pixel per chunk.
- Fully pipelined with valid/ready backpressure, a normalising right shift, saturation, and a per-beat mode (bypass / clamp / absolute-value for edge detection).
- Sits between the chunk (window) builder and the pixel output stream.

Parameters:
- K, 3, kernel side; legal values 3 and 5 (odd). Chunk holds K*K pixels.
- PW, 8, bits per colour channel (unsigned).
- CW, 9, coefficient width (signed two's complement).
- SHIFT, 0, arithmetic right shift applied to each sum; must satisfy SHIFT <= CW-2.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- i_data, in, K*K*3*PW, input chunk. Pixel index p = row*K+col, row-major. Pixel p occupies bits [p*3*PW +: 3*PW], ordered {red, grn, blu}, red in the MSBs.
- i_mode, in, 2, per-beat mode: 0 bypass, 1 clamp, 2 abs, 3 treated as bypass.
- i_last, in, 1, end-of-line marker; carried through unchanged.
- i_vld, in, 1, input valid.
- i_rdy, out, 1, input ready.
- o_data, out, 3*PW, output pixel {red, grn, blu}.
- o_last, out, 1, delayed i_last.
- o_vld, out, 1, output valid.
- o_rdy, in, 1, downstream ready.
- k_we, in, 1, shadow coefficient write enable.
- k_addr, in, 5, coefficient index (0..K*K-1). Writes with k_addr >= K*K are ignored.
- k_wdata, in, CW, coefficient value.
- k_commit, in, 1, copy shadow bank to active bank.

Behaviour:
- Reset (rst=0, asynchronous): o_vld=0, o_data=0, o_last=0, all stage valids=0.
  - Active and shadow banks reset to identity: centre coefficient = 2^SHIFT, all others 0.
  - Leaving reset mid-transfer discards all in-flight beats.
- Handshake:
  - advance = o_rdy | ~o_vld; i_rdy = advance (combinational).
  - A beat is accepted when i_vld & i_rdy.
  - All stages shift only when advance=1, so a stall holds every stage, and o_data/o_last stay stable while o_vld & ~o_rdy.
  - Bubbles propagate as invalid stages and do not block acceptance.
- Pipeline, latency 3 cycles from acceptance to o_vld when unstalled; throughput 1 beat/cycle.
  - S1: register K*K*3 signed products pixel*coef (width PW+CW+1), plus the centre pixel, mode and last.
  - S2: adder tree. Sum width SW = PW+CW+1+ceil(log2(K*K)). No intermediate overflow is possible.
  - S3: post-process into the output register.
- Post-process, per channel:
  - mode 1: v = sum >>> SHIFT (arithmetic, floor); clamp to [0, 2^PW-1].
  - mode 2: v = |sum| >>> SHIFT; clamp to 2^PW-1.
  - mode 0/3: output the centre pixel unchanged (pixel index (K*K-1)/2).
- Coefficients:
  - k_we writes the shadow bank at the clock edge.
  - k_commit copies shadow to active at the clock edge. Beats accepted in the same cycle as k_commit use the OLD active bank; beats accepted afterwards use the new one. In-flight beats are never altered.
  - k_we and k_commit in the same cycle: the commit copies the pre-write shadow; the write lands in shadow only.
- Mode and last are sampled at acceptance and travel with the beat. A mode change never affects beats already in flight.

Test Plan:
- Reset identity: after reset, K=3, SHIFT=0, mode 1, centre pixel {10,20,30}, others 255 -> o_data {10,20,30} exactly 3 cycles after acceptance; o_last follows i_last.
- Box blur: commit all-ones kernel with SHIFT=3 (instance parameter), all pixels {80,80,80} -> 720>>>3 = {90,90,90}. All pixels 255 -> 2295>>>3 = 286, clamped to {255,255,255}.
- Signed / abs: Sobel-X kernel [-1 0 1; -2 0 2; -1 0 1], SHIFT=0; left column 200, right column 0, red only.
  - mode 1 -> red 0 (sum -800 clamped).
  - mode 2 -> red 255 (|−800| clamped).
  - Left 10, right 0: mode 2 -> red 40.
- Backpressure: stream 8 beats with incrementing centre values in bypass mode, holding o_rdy low for 4 cycles mid-stream -> no loss or duplication, o_data stable while stalled, i_rdy low during the stall, order preserved.
- Commit timing: write new coefficients, assert k_commit in the same cycle as an acceptance -> that beat uses the old kernel, the next beat uses the new kernel. An out-of-range k_addr write has no effect.
- Async reset mid-stream: drop rst with 3 beats in flight -> o_vld=0 immediately, coefficients return to identity, and nothing from the old stream emerges after release.
